// File: rtl/vpe_pkg.sv
// Shared opcodes, element-width encodings and FSM states for the vector PE.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vpe_pkg;

    localparam logic [7:0] OP_VADD = 8'h00;
    localparam logic [7:0] OP_VMUL = 8'h01;
    localparam logic [7:0] OP_VDOT = 8'h02;

    localparam logic [9:0] SEW_8  = 10'd8;
    localparam logic [9:0] SEW_16 = 10'd16;
    localparam logic [9:0] SEW_32 = 10'd32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_REDUCE,
        S_FIN
    } state_t;

    // True when both the opcode and the element width are supported.
    function automatic logic op_legal(input logic [7:0] op, input logic [9:0] sew);
        logic sew_ok;
        logic op_ok;
        sew_ok = (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32);
        op_ok  = (op == OP_VADD) || (op == OP_VMUL) || (op == OP_VDOT);
        return sew_ok && op_ok;
    endfunction

endpackage

// File: rtl/vpe_serial_mul_lane.sv
// One unsigned shift-add multiplier lane with a 2*MAX_SEW partial accumulator.
// Latency: MAX-width product after ceil(width/MUL_BPC) step cycles following load.
// Backpressure: none; the parent sequences load/step and ignores the lane otherwise.
module vpe_serial_mul_lane
    import vpe_pkg::*;
#(
    parameter int MAX_SEW = 32,
    parameter int MUL_BPC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [MAX_SEW-1:0] mcand,
    input  logic [MAX_SEW-1:0] mplier,
    output logic [MAX_SEW-1:0] prod
);

    logic [2*MAX_SEW-1:0] acc;
    logic [2*MAX_SEW-1:0] acc_nxt;
    logic [2*MAX_SEW-1:0] mcand_sh;
    logic [MAX_SEW-1:0]   mplier_sh;
    logic [2*MAX_SEW-1:0] partial;

    // The low MUL_BPC multiplier bits pick a multiple of the already-shifted multiplicand;
    // prod shows the accumulator as it will be after this cycle, so it is final in the last step.
    always_comb begin
        partial = '0;
        for (int b = 0; b < MUL_BPC; b++) begin
            if (mplier_sh[b]) begin
                partial = partial + (mcand_sh << b);
            end
        end
        acc_nxt = step ? (acc + partial) : acc;
        prod    = acc_nxt[MAX_SEW-1:0];
    end

    // Load clears the accumulator; each step consumes MUL_BPC multiplier bits, LSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
        end else if (load) begin
            acc       <= '0;
            mcand_sh  <= {{MAX_SEW{1'b0}}, mcand};
            mplier_sh <= mplier;
        end else if (step) begin
            acc       <= acc_nxt;
            mcand_sh  <= mcand_sh << MUL_BPC;
            mplier_sh <= mplier_sh >> MUL_BPC;
        end
    end

endmodule

// File: rtl/vector_pe_multicycle.sv
// Multi-cycle vector PE: lane-wise add, serial multiply and dot-product over packed SEW lanes.
// Latency: vadd/illegal T+1, vmul T+1+SEW/MUL_BPC, vdot T+2+SEW/MUL_BPC from the accept cycle.
// Backpressure: start is only sampled in IDLE; requests while busy or in the done cycle are dropped.
module vector_pe_multicycle
    import vpe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      instruction,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [XLEN-1:0] opC,
    input  logic [9:0]      SEW,
    output logic [XLEN-1:0] peout
);

    localparam int LANES  = XLEN / 8;
    localparam int BPC_LG = $clog2(MUL_BPC);

    state_t          state_q, state_d;
    logic [7:0]      op_q;
    logic [9:0]      sew_q;
    logic [XLEN-1:0] opc_q;
    logic            ill_q;
    logic [5:0]      cnt_q;
    logic            accept;
    logic            ill_in;

    logic [31:0]     lane_prod [LANES];
    logic [XLEN-1:0] add8, add16, add32, add_res;
    logic [XLEN-1:0] mul8, mul16, mul32, mul_res;
    logic [XLEN-1:0] dot_res;

    assign accept = (state_q == S_IDLE) && start;
    assign ill_in = !op_legal(instruction, SEW);

    // Byte lanes are regrouped per SEW: at 16/32 bits only every 2nd/4th lane owns an element.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0] a16, b16, a32, b32;
        logic [31:0] mcand, mplier;

        assign add8[8*i +: 8] = opA[8*i +: 8] + opB[8*i +: 8];
        assign mul8[8*i +: 8] = lane_prod[i][7:0];

        if (i < LANES/2) begin : g_w16
            assign a16 = 32'(opA[16*i +: 16]);
            assign b16 = 32'(opB[16*i +: 16]);
            assign add16[16*i +: 16] = opA[16*i +: 16] + opB[16*i +: 16];
            assign mul16[16*i +: 16] = lane_prod[i][15:0];
        end else begin : g_n16
            assign a16 = '0;
            assign b16 = '0;
        end

        if (i < LANES/4) begin : g_w32
            assign a32 = opA[32*i +: 32];
            assign b32 = opB[32*i +: 32];
            assign add32[32*i +: 32] = opA[32*i +: 32] + opB[32*i +: 32];
            assign mul32[32*i +: 32] = lane_prod[i][31:0];
        end else begin : g_n32
            assign a32 = '0;
            assign b32 = '0;
        end

        // Lanes that own no element at this width multiply zero so the dot sum can add every lane.
        always_comb begin
            case (SEW)
                SEW_16:  begin mcand = a16; mplier = b16; end
                SEW_32:  begin mcand = a32; mplier = b32; end
                default: begin mcand = 32'(opA[8*i +: 8]); mplier = 32'(opB[8*i +: 8]); end
            endcase
        end

        vpe_serial_mul_lane #(
            .MAX_SEW (32),
            .MUL_BPC (MUL_BPC)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (accept),
            .step   (state_q == S_MUL),
            .mcand  (mcand),
            .mplier (mplier),
            .prod   (lane_prod[i])
        );
    end

    // Result selection: vadd uses the live width at accept, vmul the latched width.
    always_comb begin
        case (SEW)
            SEW_16:  add_res = add16;
            SEW_32:  add_res = add32;
            default: add_res = add8;
        endcase
        case (sew_q)
            SEW_8:   mul_res = mul8;
            SEW_16:  mul_res = mul16;
            SEW_32:  mul_res = mul32;
            default: mul_res = '0;
        endcase
    end

    // Dot product: accumulator plus every lane product truncated to 32 bits, wrapping at XLEN.
    always_comb begin
        dot_res = opc_q;
        for (int i = 0; i < LANES; i++) begin
            dot_res = dot_res + XLEN'(lane_prod[i]);
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FIN);
        illegal = (state_q == S_FIN) && ill_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (ill_in || instruction == OP_VADD) ? S_FIN : S_MUL;
            S_MUL:    if (cnt_q == 6'd1) state_d = (op_q == OP_VDOT) ? S_REDUCE : S_FIN;
            S_REDUCE: state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, operand latches, step counter and the held result; peout is written on the edge into FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sew_q   <= '0;
            opc_q   <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            peout   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= instruction;
                sew_q <= SEW;
                opc_q <= opC;
                ill_q <= ill_in;
                cnt_q <= 6'(SEW >> BPC_LG);
                if (ill_in) begin
                    peout <= '0;
                end else if (instruction == OP_VADD) begin
                    peout <= add_res;
                end
            end
            if (state_q == S_MUL) begin
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd1 && op_q == OP_VMUL) begin
                    peout <= mul_res;
                end
            end
            if (state_q == S_REDUCE) begin
                peout <= dot_res;
            end
        end
    end

endmodule

// File: tb/tb_vector_pe_multicycle.sv
// Directed bench for vector_pe_multicycle (XLEN=32, MUL_BPC=1) with hand-computed results.
// Latency: measured from the accept cycle and compared with the expected cycle count.
// Backpressure: exercises starts issued while busy and in the done cycle.
module tb_vector_pe_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instruction = 8'h00;
    logic        start = 1'b0;
    logic        busy, done, illegal;
    logic [31:0] opA = '0, opB = '0, opC = '0;
    logic [9:0]  SEW = 10'd8;
    logic [31:0] peout;

    int n_cmp = 0;
    int n_err = 0;

    vector_pe_multicycle #(.XLEN(32), .MUL_BPC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .opA         (opA),
        .opB         (opB),
        .opC         (opC),
        .SEW         (SEW),
        .peout       (peout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then scramble every input to prove it was latched.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [9:0] sew);
        @(negedge clk);
        instruction = op; opA = a; opB = b; opC = c; SEW = sew; start = 1'b1;
        @(negedge clk);
        start = 1'b0; instruction = 8'hFF; SEW = 10'd12;
        opA = 32'hDEADBEEF; opB = 32'hCAFEF00D; opC = 32'h5A5A5A5A;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [9:0] sew,
                          input int exp_lat, input logic [31:0] exp_out, input logic exp_ill);
        int lat;
        issue(op, a, b, c, sew);
        lat = 1;
        if (exp_lat > 1) chk({tag, "_busy"}, busy, 1);
        while (done !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_peout"}, peout, exp_out);
        chk({tag, "_illegal"}, illegal, exp_ill);
        @(negedge clk);
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_peout", peout, 0);
        reset = 1'b0;

        // Lane-wise add: carries must not cross byte boundaries.
        run_op("vadd8", 8'h00, 32'hFF01_7F80, 32'h0101_0180, 32'h0, 10'd8, 1, 32'h0002_8000, 1'b0);
        run_op("vadd16", 8'h00, 32'h0001_FFFF, 32'h0001_0001, 32'h0, 10'd16, 1, 32'h0002_0000, 1'b0);

        // Multiplies at each width.
        run_op("vmul8", 8'h01, 32'h10FF_0302, 32'h10FF_0507, 32'h0, 10'd8, 9, 32'h0001_0F0E, 1'b0);

        // vmul SEW=16 with starts while busy and in the done cycle.
        issue(8'h01, 32'h0003_FFFF, 32'h0005_0002, 32'h0, 10'd16);
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            if (lat == 4) begin
                start = 1'b1; instruction = 8'h00; SEW = 10'd8;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("vmul16_lat", lat, 17);
        chk("vmul16_peout", peout, 32'h000F_FFFE);
        start = 1'b1; instruction = 8'h00; SEW = 10'd8; opA = 32'h1111_1111; opB = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done", done, 0);
        chk("b2b_busy", busy, 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("b2b_no_second_done", ndone, 0);
        chk("b2b_peout_held", peout, 32'h000F_FFFE);

        // Fresh start after the ignored ones is accepted normally.
        run_op("vadd_fresh", 8'h00, 32'h1234_5678, 32'h0101_0101, 32'h0, 10'd8, 1, 32'h1335_5779, 1'b0);

        // Dot products, including truncation of a 32-bit product and accumulator wrap.
        run_op("vdot8", 8'h02, 32'h0102_0304, 32'h0505_0505, 32'h0000_0010, 10'd8, 10, 32'h0000_0042, 1'b0);
        run_op("vdot16", 8'h02, 32'h0002_0003, 32'h0004_0005, 32'hFFFF_FFFF, 10'd16, 18, 32'h0000_0016, 1'b0);
        run_op("vdot32", 8'h02, 32'h0001_0000, 32'h0001_0003, 32'h0000_0005, 10'd32, 34, 32'h0003_0005, 1'b0);

        // Illegal width with a valid opcode, and illegal opcode with a valid width.
        run_op("ill_sew", 8'h00, 32'h0101_0101, 32'h0101_0101, 32'h0, 10'd12, 1, 32'h0, 1'b1);
        run_op("vadd32", 8'h00, 32'h0000_0001, 32'h0000_0002, 32'h0, 10'd32, 1, 32'h0000_0003, 1'b0);
        run_op("ill_op", 8'h07, 32'h0101_0101, 32'h0101_0101, 32'h0, 10'd32, 1, 32'h0, 1'b1);

        // Reset in the middle of a SEW=32 multiply.
        run_op("vadd_pre", 8'h00, 32'h0000_0001, 32'h0000_0002, 32'h0, 10'd32, 1, 32'h0000_0003, 1'b0);
        issue(8'h01, 32'h1234_5678, 32'h9ABC_DEF1, 32'h0, 10'd32);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_peout", peout, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vector_pe_multicycle.md
Name: vector_pe_multicycle

Overview:
Parametrised, multi-cycle vector processing element for the vector coprocessor datapath.
- Accepts one element-group operation per start/done handshake.
- Operates on XLEN/SEW packed lanes.
- Adds lane-wise multiply via a bit-serial shift-add engine and a dot-product with reduction into opC.
- Drop-in successor ALU: the coprocessor issues an opcode plus operands and waits for done.

Parameters:
XLEN, 32, operand/result width; must be a multiple of 32.
MUL_BPC, 1, multiplier bits consumed per cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
instruction  input  8  opcode: 0x00 vadd.vv, 0x01 vmul.vv, 0x02 vdot.vv; all others illegal.
start  input  1  request; sampled only in IDLE.
busy  output  1  high from the cycle after accept until the done cycle, inclusive.
done  output  1  one-cycle completion pulse.
illegal  output  1  high with done when the opcode or SEW is unsupported.
opA  input  XLEN  packed source vector A.
opB  input  XLEN  packed source vector B (multiplier for vmul/vdot).
opC  input  XLEN  accumulator input for vdot.
SEW  input  10  element width: 8, 16 or 32.
peout  output  XLEN  result; holds its value until the next done.

Behaviour:
- Reset (synchronous, active-high, on clk): peout=0, done=0, busy=0, illegal=0, FSM=IDLE. Reset mid-operation aborts with no done pulse; partial products are discarded.
- FSM states: IDLE, MUL, REDUCE, FIN.
  - IDLE + start: latch instruction, opA, opB, opC, SEW into internal registers. Inputs are don't-care afterwards.
  - vadd, or any illegal case: go to FIN.
  - vmul/vdot: go to MUL with iteration counter = SEW/MUL_BPC.
- MUL:
  - Each cycle, every lane adds the multiplicand shifted by (MUL_BPC × iteration) times the next MUL_BPC bits of its multiplier, LSB first.
  - Lanes are unsigned, and each lane has a 2×SEW-bit partial accumulator.
  - Counter reaches 0: vmul goes to FIN, vdot goes to REDUCE.
- REDUCE (vdot only, 1 cycle): sum = opC + Σ lane products, each product truncated to 32 bits, result mod 2^XLEN. Then go to FIN.
- FIN: drive peout and done=1 for exactly one cycle, busy=1; return to IDLE next cycle.
- Result rules:
  - vadd: per-lane sum mod 2^SEW; no carry crosses lane boundaries.
  - vmul: each lane holds the low SEW bits of its product.
  - vdot: peout = REDUCE sum.
  - illegal: peout=0, illegal=1.
- Latency, from accept cycle T:
  - vadd or illegal: done at T+1.
  - vmul: done at T+1+SEW/MUL_BPC.
  - vdot: done at T+2+SEW/MUL_BPC.
- start while busy is ignored, never queued. A new start is accepted no earlier than the cycle after done (back-to-back issue: start asserted in the done cycle is ignored).
- SEW or instruction changes after accept have no effect.
- SEW not in {8, 16, 32}: flagged illegal, even when the opcode is valid.

Decomposition:
- Shared package vpe_pkg:
  - opcode localparams: OP_VADD=8'h00, OP_VMUL=8'h01, OP_VDOT=8'h02.
  - SEW encodings: SEW_8, SEW_16, SEW_32.
  - FSM state encodings.
- One natural sub-module, vpe_serial_mul_lane: one lane's shift-add step and partial accumulator. Parametrised by max SEW and MUL_BPC; instantiated XLEN/8 times with SEW-dependent lane grouping muxed in the parent.

Test Plan:
- vadd SEW=8, opA=0xFF01_7F80, opB=0x0101_0180 -> done at T+1, peout=0x0002_8000, busy low after done.
- vmul SEW=16, opA=0x0003_FFFF, opB=0x0005_0002, MUL_BPC=1 -> done exactly at T+17, peout=0x000F_FFFE.
- vdot SEW=8, opA=0x0102_0304, opB=0x0505_0505, opC=0x0000_0010 -> done at T+10, peout=0x0000_0042.
- SEW=12 with vadd, and opcode 0x07 with SEW=32 -> done at T+1, illegal=1, peout=0.
- start pulsed during vmul busy and in its done cycle -> ignored; no second done; then a fresh start is accepted normally.
- reset asserted mid-MUL (cycle T+5, SEW=32) -> next cycle busy=0, done=0, peout=0; no done pulse follows.
